// File: rtl/vga_sync_rx.sv
// Display sync receiver: recovers sx/sy, frame/line strobes, line period and lock from hsync/vsync/de.
// Optional VGA_RX_ERRCNT_EN builds a saturating 8-bit error counter on err_cnt.
module vga_sync_rx #(
    parameter int CORDW       = 16,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de_out,
    output logic             frame,
    output logic             line,
    output logic [CORDW-1:0] h_total,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);
    localparam logic [CORDW-1:0] CMAX     = '1;
    localparam logic [CORDW-1:0] ONE      = CORDW'(1);
    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] V_RES_W  = CORDW'(V_RES);
    localparam logic [3:0]       LOCK_W   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    logic hs_q, hs_p_q, vs_q, vs_p_q, de_q, de_p_q;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, hcnt_q, hcnt_d, h_total_q, h_total_d;
    logic [CORDW-1:0] line_cnt_q, line_cnt_d;
    logic de_out_q, de_out_d, frame_q, frame_d, line_q, line_d;
    logic sof_pend_q, sof_pend_d, frame_bad_q, frame_bad_d;
    logic hs_edge, vs_edge, de_rise, de_fall, width_bad, height_bad, frame_bad_now;
    state_t     state_q;
    logic [3:0] good_cnt_q;
    logic       locked_q, err_q;

    always_comb begin
        hs_edge       = (hs_q == SYNC_POL) && (hs_p_q != SYNC_POL);
        vs_edge       = (vs_q == SYNC_POL) && (vs_p_q != SYNC_POL);
        de_rise       = de_q && !de_p_q;
        de_fall       = !de_q && de_p_q;
        // sx_q still holds the last pixel index of the run that just ended
        width_bad     = de_fall && (sx_q != H_LAST);
        height_bad    = vs_edge && ((line_cnt_q != V_RES_W) || (line_cnt_q == '0));
        frame_bad_now = frame_bad_q || width_bad || height_bad;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        sx_d        = sx_q;
        sy_d        = sy_q;
        de_out_d    = de_q;
        line_d      = de_rise;
        frame_d     = de_rise && sof_pend_q;
        sof_pend_d  = vs_edge || (sof_pend_q && !de_rise);
        frame_bad_d = vs_edge ? 1'b0 : (frame_bad_q || width_bad);
        line_cnt_d  = vs_edge ? '0 : line_cnt_q;
        hcnt_d      = (hcnt_q != CMAX) ? hcnt_q + ONE : hcnt_q;
        h_total_d   = h_total_q;

        if (de_rise) begin
            sx_d = '0;
            if (sof_pend_q)        sy_d = '0;
            else if (sy_q != CMAX) sy_d = sy_q + ONE;
            if (line_cnt_d != CMAX) line_cnt_d = line_cnt_d + ONE;
        end else if (de_q && sx_q != CMAX) begin
            sx_d = sx_q + ONE;
        end

        if (hs_edge) begin
            hcnt_d    = '0;
            h_total_d = (hcnt_q != CMAX) ? hcnt_q + ONE : hcnt_q;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            hs_q        <= !SYNC_POL;
            hs_p_q      <= !SYNC_POL;
            vs_q        <= !SYNC_POL;
            vs_p_q      <= !SYNC_POL;
            de_q        <= 1'b0;
            de_p_q      <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            de_out_q    <= 1'b0;
            frame_q     <= 1'b0;
            line_q      <= 1'b0;
            sof_pend_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            line_cnt_q  <= '0;
            hcnt_q      <= '0;
            h_total_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hs_q        <= hsync;
            hs_p_q      <= hs_q;
            vs_q        <= vsync;
            vs_p_q      <= vs_q;
            de_q        <= de;
            de_p_q      <= de_q;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            de_out_q    <= de_out_d;
            frame_q     <= frame_d;
            line_q      <= line_d;
            sof_pend_q  <= sof_pend_d;
            frame_bad_q <= frame_bad_d;
            line_cnt_q  <= line_cnt_d;
            hcnt_q      <= hcnt_d;
            h_total_q   <= h_total_d;
        end
    end

    // The first vsync edge only arms measurement; the partial frame before it is never judged.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q    <= IDLE;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vs_edge) begin
                        state_q    <= MEASURE;
                        good_cnt_q <= '0;
                    end
                end
                MEASURE: begin
                    err_q <= width_bad || height_bad;
                    if (vs_edge) begin
                        if (frame_bad_now) begin
                            good_cnt_q <= '0;
                        end else if (good_cnt_q + 4'd1 == LOCK_W) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    err_q <= width_bad || height_bad;
                    if (width_bad || height_bad) begin
                        state_q    <= MEASURE;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign sx      = sx_q;
    assign sy      = sy_q;
    assign de_out  = de_out_q;
    assign frame   = frame_q;
    assign line    = line_q;
    assign h_total = h_total_q;
    assign locked  = locked_q;
    assign err     = err_q;
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
Display sync receiver: the inverse of the 480p sync generator. Consumes hsync/vsync/de in the pixel clock domain and recovers active-area coordinates sx/sy and frame/line strobes. Measures line period and active geometry, and asserts lock once the timing matches the expected resolution. Used for loopback checking of the VGA output path and as the front end of future video-capture blocks.

Parameters:
CORDW, 16, coordinate and counter width in bits (unsigned here)
H_RES, 640, expected active pixels per line
V_RES, 480, expected active lines per frame
SYNC_POL, 0, sync active level (0 = active-low, as 480p)
LOCK_FRAMES, 2, consecutive good frames required to assert locked (1-15)

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  reset, asynchronous, active-high
hsync  in  1  horizontal sync, polarity per SYNC_POL
vsync  in  1  vertical sync, polarity per SYNC_POL
de  in  1  data enable, active-high
sx  out  CORDW  recovered active x, valid when de_out
sy  out  CORDW  recovered active y, valid when de_out
de_out  out  1  delayed de, aligned with sx/sy
frame  out  1  one-cycle strobe with first pixel of line sy==0
line  out  1  one-cycle strobe with first pixel of every active line
h_total  out  CORDW  clocks between last two hsync active edges
locked  out  1  timing matches H_RES x V_RES
err  out  1  one-cycle strobe on any width/height mismatch
err_cnt  out  8  saturating error count (see Optional Feature)

Behaviour:
- Single clock; async reset forces every output to 0 and the FSM to IDLE.
- Inputs registered once; outputs registered; sx/sy/de_out/frame/line lag the inputs by exactly 2 cycles.
- Sync edge = transition of hsync/vsync into the active level (SYNC_POL).
- Pixel counter: on de rising edge, sx=0 and line=1; sx increments each de-high cycle and saturates at 2^CORDW-1.
- Line counter: first de rising edge after a vsync edge gives sy=0 and frame=1; each later de rising edge gives sy+1 (saturating).
- Width check at each de falling edge: run length != H_RES -> frame marked bad.
- Height check at each vsync edge: line count != V_RES -> frame marked bad. Frame with zero lines is bad.
- h_total: free-running counter cleared at each hsync edge; previous value latched into h_total. Saturates; holds its value if hsync stops.
- FSM IDLE -> MEASURE on first vsync edge; counters start then. Partial first frame is not judged.
- MEASURE: at each vsync edge, good frame -> good_cnt+1, bad frame -> good_cnt=0. good_cnt==LOCK_FRAMES -> LOCKED.
- LOCKED: width mismatch drops to MEASURE immediately (locked=0 on the following cycle) with good_cnt=0. Height mismatch at vsync does the same.
- err pulses one cycle per detected mismatch (width or height), in any state except IDLE.
- vsync edge in the same cycle as a de falling edge: the width check is applied first, then the frame is judged.
- sx/sy continue to update when unlocked; consumers gate on locked.

Optional Feature:
VGA_RX_ERRCNT_EN:
- Defined: err_cnt increments on each err pulse, saturates at 255, and is cleared only by rst_pix.
- Undefined: err_cnt is tied to 0 and no counter logic is generated.
- The port exists in both builds.

Test Plan:
- Standard 640x480 timing (800x525, active-low sync) for 3 frames -> locked=1 after 2nd full frame vsync edge; h_total=800; sx spans 0..639; sy spans 0..479.
- During lock -> frame pulses exactly once per frame, coincident with sx=0, sy=0; line pulses 480 times per frame; outputs 2 cycles after the input de edge.
- One line with de high for 639 cycles while locked -> err=1 for one cycle; locked=0 next cycle; relock after 2 good frames; err_cnt=1 with VGA_RX_ERRCNT_EN.
- Frame with 479 active lines -> err at vsync edge, no lock increment; 2 good frames then required.
- Assert rst_pix mid-line -> all outputs 0 immediately (asynchronous); after release, no lock before 1 partial + 2 full frames.
- SYNC_POL=1 with inverted syncs -> identical sx/sy/lock results; 300 error frames with the macro defined -> err_cnt=255.
